mod3_share_sched: RTL
=====================

# mod3_share_sched

Round-robin scheduler that shares one serial mod-3 residue engine among `NUM_REQ` requesters. It accepts a `WIDTH`-bit word from the winning requester and feeds it MSB-first through the mod-3 residue recurrence, one bit per cycle. It then returns the remainder, a divisible-by-3 flag and the requester ID on a valid/ready result port. It sits between several producers needing divisibility checks and a single result consumer, replacing per-requester residue FSMs.

## Interface
- `NUM_REQ`, default 4: number of requesters; must be ≥2.
- `WIDTH`, default 8: bits per word; must be ≥1.
- `IDW`, default `$clog2(NUM_REQ)`: result ID width. Derived; not overridden.
- `clk`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester word-available.
- `req_data`  in  NUM_REQ*WIDTH  word for requester i at `[i*WIDTH +: WIDTH]`, unsigned, MSB first.
- `req_ready`  out  NUM_REQ  one-hot acceptance; word i is taken when `req_valid[i] && req_ready[i]`.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts result.
- `res_id`  out  IDW  index of the requester that owns the result.
- `res_rem`  out  2  word mod 3, in the range 0..2.
- `res_div`  out  1  1 when `res_rem == 0`.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE
  - If any `req_valid` is set, grant the first set requester searching from `last_grant+1` upward, modulo NUM_REQ.
  - `req_ready` = one-hot grant, combinational from `req_valid` and `last_grant`. It is all-zero when nothing is valid or the state is not IDLE.
  - On handshake: capture the word into a shift register and the grant index into `res_id`. Clear residue to 0, clear the bit counter, set `last_grant` to the index, and go to SHIFT.
- SHIFT
  - Each cycle, take the shift register MSB as `b`, set `rem <= (2*rem + b) mod 3`, shift left, and increment the counter.
  - Transitions: rem0: b0→0, b1→1. rem1: b0→2, b1→0. rem2: b0→1, b1→2.
  - After exactly WIDTH bits, go to DONE.
- DONE
  - `res_valid` = 1. `res_id`, `res_rem` and `res_div` are held stable.
  - On `res_valid && res_ready`, go to IDLE.
- Requesters see no `req_ready` during SHIFT or DONE. `req_valid` may drop before grant without consequence. `req_data` only needs to be valid in the accept cycle.
- Residue register is 2 bits and never holds 3.
- Counter width is `$clog2(WIDTH+1)`.

## Timing
- Reset values:
  - state IDLE, `last_grant` = NUM_REQ-1, so requester 0 wins first.
  - `req_ready` 0, `res_valid` 0, `res_id` 0, `res_rem` 0, `res_div` 0 (0 until the first result, since the flag is gated by `res_valid`).
- Latency: accept at cycle T → `res_valid` rises at T+WIDTH+1.
- Throughput: with `res_ready` held high, one word every WIDTH+2 cycles (DONE cycle, then accept cycle in IDLE).
- No accept can occur in the same cycle as a result handshake. The FSM must pass through IDLE first.
- Backpressure: `res_ready` low in DONE holds all result outputs unchanged indefinitely and keeps `req_ready` at 0.
- Reset asserted in any state: next edge returns everything to reset values. An in-flight word is discarded and no result is produced. Reset has priority over any handshake in the same cycle.
- A new arrival on a higher-priority requester during SHIFT does not preempt the current word.

## Test plan
- Single request, NUM_REQ=4, WIDTH=8: req 2 valid with 8'd9 → `req_ready` = 4'b0100 same cycle; 9 cycles later `res_valid`=1, `res_id`=2, `res_rem`=0, `res_div`=1.
- Remainder coverage: words 8'd7, 8'd128, 8'd255, 8'd0 → `res_rem` = 1, 2, 0, 0 and `res_div` = 0, 0, 1, 1.
- Fairness: all four `req_valid` held high and `res_ready` high → grant order 0,1,2,3,0,1, with one accept every 10 cycles.
- Backpressure: hold `res_ready` low for 5 cycles in DONE → outputs stable, `req_ready` = 0. Raising `res_ready` → `res_valid` drops the next cycle and the next grant follows.
- Reset mid-SHIFT: assert `reset` 3 cycles after accepting req 1 → next cycle state IDLE, `res_valid` 0, no result emitted. A subsequent request from req 1 and req 0 grants req 0 first.
- Edge parameter, WIDTH=1: word 1'b1 → `res_rem`=1, `res_valid` 2 cycles after accept. Word 1'b0 → `res_div`=1.

Source files
------------

// File: rtl/mod3_share_sched_if.sv
// Requester/result bundle for the shared mod-3 residue scheduler.
// The scheduler takes the slave side; the producers and consumer take the master side.
interface mod3_share_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     res_valid;
    logic                     res_ready;
    logic [IDW-1:0]           res_id;
    logic [1:0]               res_rem;
    logic                     res_div;

    modport slave (
        input  req_valid, req_data, res_ready,
        output req_ready, res_valid, res_id, res_rem, res_div
    );

    modport master (
        output req_valid, req_data, res_ready,
        input  req_ready, res_valid, res_id, res_rem, res_div
    );
endinterface

// File: rtl/mod3_share_sched.sv
// Round-robin arbiter in front of one bit-serial mod-3 residue engine.
// One word at a time: accept in IDLE, WIDTH shift cycles, then hold the result in DONE.
module mod3_share_sched #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
) (
    input  logic               clk,
    input  logic               reset,
    mod3_share_sched_if.slave  bus
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state, state_nxt;
    logic [IDW-1:0]     last_grant, grant_idx, res_id_q;
    logic [NUM_REQ-1:0] grant_oh;
    logic               any_grant;
    logic [WIDTH-1:0]   sreg;
    logic [1:0]         rem, rem_nxt;
    logic [CW-1:0]      cnt;
    int                 idx;

    // Search starts just past the previous winner so every requester gets a turn.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (!any_grant && bus.req_valid[idx]) begin
                any_grant = 1'b1;
                grant_idx = IDW'(idx);
            end
        end
        if (any_grant)
            grant_oh[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.req_ready = '0;
        case (state)
            IDLE: begin
                bus.req_ready = grant_oh;
                if (any_grant)
                    state_nxt = SHIFT;
            end
            SHIFT: if (cnt == CW'(WIDTH - 1)) state_nxt = DONE;
            DONE:  if (bus.res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // rem' = (2*rem + b) mod 3, keyed on {rem, b}; rem never reaches 3.
    always_comb begin
        case ({rem, sreg[WIDTH-1]})
            3'b001:  rem_nxt = 2'd1;
            3'b010:  rem_nxt = 2'd2;
            3'b100:  rem_nxt = 2'd1;
            3'b101:  rem_nxt = 2'd2;
            default: rem_nxt = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= IDW'(NUM_REQ - 1);
            res_id_q   <= '0;
            sreg       <= '0;
            rem        <= '0;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: if (any_grant) begin
                    sreg       <= bus.req_data[grant_idx*WIDTH +: WIDTH];
                    res_id_q   <= grant_idx;
                    last_grant <= grant_idx;
                    rem        <= '0;
                    cnt        <= '0;
                end
                SHIFT: begin
                    rem  <= rem_nxt;
                    sreg <= sreg << 1;
                    cnt  <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.res_valid = (state == DONE);
    assign bus.res_id    = res_id_q;
    assign bus.res_rem   = rem;
    assign bus.res_div   = (state == DONE) && (rem == 2'd0);
endmodule
